// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: N valid/ready requesters share one registered output; a grant lasts up to weight beats.
// Latency: request to o_ready 1 cycle, to o_valid 2 cycles. Backpressure stalls the granted requester without using credit.
// Optional WRR_ARB_LAST_EN: adds i_last/o_last, and credit then counts packets instead of beats.
module wrr_arbiter #(
    parameter int N  = 4,
    parameter int D  = 32,
    parameter int WW = 4,
    localparam int IW = $clog2(N)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N-1:0]    i_valid,
    output logic [N-1:0]    o_ready,
    input  logic [N*D-1:0]  i_data,
    input  logic [N*WW-1:0] i_weight,
`ifdef WRR_ARB_LAST_EN
    input  logic [N-1:0]    i_last,
    output logic            o_last,
`endif
    output logic            o_valid,
    input  logic            i_ready,
    output logic [D-1:0]    o_data,
    output logic [N-1:0]    o_grant,
    output logic [IW-1:0]   o_grant_idx
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [WW-1:0]   credit;

    logic [IW-1:0]   sel;
    logic            any;
    logic [WW-1:0]   new_w;
    logic [WW-1:0]   load;
    logic [IW-1:0]   next_ptr;
    logic [D-1:0]    gdata;
    logic            gvalid;
    logic            accept;
    logic            dec;
    logic            rel;
    int              j;

`ifdef WRR_ARB_LAST_EN
    logic            in_pkt;
    logic            is_last;
`endif

    // Downward scan so the last hit is the smallest rotation from ptr.
    always_comb begin
        sel = '0;
        any = 1'b0;
        j   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (i_valid[j]) begin
                sel = IW'(j);
                any = 1'b1;
            end
        end
    end

    always_comb begin
        new_w    = i_weight[int'(sel)*WW +: WW];
        load     = (new_w == '0) ? WW'(1) : new_w;
        next_ptr = (o_grant_idx == IW'(N - 1)) ? '0 : o_grant_idx + 1'b1;
        gdata    = i_data[int'(o_grant_idx)*D +: D];
        gvalid   = i_valid[o_grant_idx];
        accept   = (state == GRANT) && gvalid && (!o_valid || i_ready);
    end

`ifdef WRR_ARB_LAST_EN
    always_comb begin
        is_last = i_last[o_grant_idx];
        dec     = accept && is_last;
        rel     = (dec && credit == WW'(1)) || (!gvalid && !in_pkt);
    end
`else
    always_comb begin
        dec = accept;
        rel = (accept && credit == WW'(1)) || !gvalid;
    end
`endif

    always_comb begin
        o_ready = '0;
        if (!i_rst && accept) o_ready[o_grant_idx] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            ptr         <= '0;
            credit      <= '0;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_grant     <= '0;
            o_grant_idx <= '0;
`ifdef WRR_ARB_LAST_EN
            o_last      <= 1'b0;
            in_pkt      <= 1'b0;
`endif
        end else begin
            if (accept) begin
                o_valid <= 1'b1;
                o_data  <= gdata;
`ifdef WRR_ARB_LAST_EN
                o_last  <= is_last;
                in_pkt  <= !is_last;
`endif
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (any) begin
                        credit      <= load;
                        o_grant     <= N'(1) << sel;
                        o_grant_idx <= sel;
                        state       <= GRANT;
                    end else begin
                        o_grant <= '0;
                    end
                end
                GRANT: begin
                    if (dec) credit <= credit - WW'(1);
                    if (rel) begin
                        state   <= IDLE;
                        ptr     <= next_ptr;
                        o_grant <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Scoreboard bench for wrr_arbiter (default build): expected beats are queued from a weight model and popped on delivery.
module tb_wrr_arbiter;

    localparam int N = 4;
    localparam int D = 32;
    localparam int WW = 4;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   i_valid;
    logic [N-1:0]   o_ready;
    logic [N*D-1:0] i_data;
    logic [N*WW-1:0] i_weight;
    logic           o_valid;
    logic           i_ready;
    logic [D-1:0]   o_data;
    logic [N-1:0]   o_grant;
    logic [1:0]     o_grant_idx;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb[$];
    int exp_cnt[N];
    int cnt[N];
    logic [N-1:0] hs;
    logic rs;

    wrr_arbiter #(.N(N), .D(D), .WW(WW)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_weight(i_weight),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_grant(o_grant), .o_grant_idx(o_grant_idx)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Each requester presents {index, beat number}; the number advances on every handshake.
    always @(negedge i_clk) begin
        hs = i_valid & o_ready;
        rs = i_rst;
    end

    always @(posedge i_clk) begin
        #1;
        for (int k = 0; k < N; k++) begin
            if (rs) cnt[k] = 0;
            else if (hs[k]) cnt[k] = cnt[k] + 1;
            i_data[k*D +: D] = (k << 16) | cnt[k];
        end
    end

    always @(negedge i_clk) begin
        chk("rdy_onehot", 32'($countones(o_ready) <= 1), 32'd1);
        if (o_valid === 1'b1 && i_ready === 1'b1) begin
            if (sb.size() == 0) chk("sb_empty_at_beat", 32'(sb.size()), 32'd0);
            else chk("beat_data", o_data, sb.pop_front());
        end
    end

    task automatic push_beat(input int k);
        sb.push_back(32'((k << 16) | exp_cnt[k]));
        exp_cnt[k]++;
    endtask

    // Round-robin from requester 0 with all requesters valid; weight 0 counts as 1.
    task automatic push_seq(input logic [15:0] w, input int rounds);
        logic [3:0] wk;
        for (int r = 0; r < rounds; r++)
            for (int k = 0; k < N; k++) begin
                wk = w[k*4 +: 4];
                if (wk == 0) wk = 1;
                for (int b = 0; b < int'(wk); b++) push_beat(k);
            end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_valid = '0;
        i_ready = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        for (int k = 0; k < N; k++) exp_cnt[k] = 0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            step();
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            exp_cnt[k] = 0;
            cnt[k] = 0;
        end
        i_rst = 1'b1;
        i_valid = '0;
        i_ready = 1'b0;
        i_weight = '0;
        step();
        step();
        @(negedge i_clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_idx", 32'(o_grant_idx), 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        step();
        i_rst = 1'b0;
        i_ready = 1'b1;

        // Equal weights: strict rotation, with latency checked on the first grant.
        i_weight = 16'h1111;
        push_seq(16'h1111, 2);
        i_valid = 4'b1111;
        @(negedge i_clk);
        chk("lat_t_ready", 32'(o_ready), 32'd0);
        step();
        @(negedge i_clk);
        chk("lat_t1_ready", 32'(o_ready), 32'b0001);
        chk("lat_t1_valid", 32'(o_valid), 32'd0);
        step();
        @(negedge i_clk);
        chk("lat_t2_valid", 32'(o_valid), 32'd1);
        drain("drain_eq");
        i_valid = '0;

        // Weights {3,1,2,1}.
        do_reset();
        i_weight = 16'h1213;
        push_seq(16'h1213, 2);
        i_valid = 4'b1111;
        drain("drain_wrr");
        i_valid = '0;

        // Single requester under downstream stall.
        do_reset();
        i_weight = 16'h0400;
        for (int b = 0; b < 4; b++) push_beat(2);
        i_valid = 4'b0100;
        step();
        step();
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            chk("stall_data", o_data, 32'h0002_0000);
            chk("stall_valid", 32'(o_valid), 32'd1);
            chk("stall_grant", 32'(o_grant), 32'b0100);
            chk("stall_ready", 32'(o_ready), 32'd0);
            step();
        end
        i_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge i_clk);
            #2;
            if (cnt[2] == 4) break;
        end
        chk("stall_beats", 32'(cnt[2]), 32'd4);
        i_valid = '0;
        drain("drain_stall");
        @(negedge i_clk);
        chk("stall_release", 32'(o_grant), 32'd0);

        // Requester 1 with weight 5 drops valid after two beats.
        do_reset();
        i_weight = 16'h0050;
        push_beat(1);
        push_beat(1);
        i_valid = 4'b0010;
        for (int i = 0; i < 50; i++) begin
            @(posedge i_clk);
            #2;
            if (cnt[1] == 2) break;
        end
        chk("drop_beats", 32'(cnt[1]), 32'd2);
        i_valid = '0;
        @(negedge i_clk);
        chk("drop_held", 32'(o_grant), 32'b0010);
        step();
        @(negedge i_clk);
        chk("drop_grant", 32'(o_grant), 32'd0);
        chk("drop_idx", 32'(o_grant_idx), 32'd1);
        step();
        i_weight = 16'h1111;
        i_valid = 4'b1111;
        push_beat(2);
        step();
        @(negedge i_clk);
        chk("drop_ptr_idx", 32'(o_grant_idx), 32'd2);
        chk("drop_ptr_grant", 32'(o_grant), 32'b0100);
        step();
        i_valid = '0;
        drain("drain_drop");

        // Reset while a beat is held and a grant is active.
        do_reset();
        i_weight = 16'h4444;
        i_valid = 4'b1111;
        step();
        step();
        i_ready = 1'b0;
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("mid_rst_ready", 32'(o_ready), 32'd0);
        chk("mid_rst_pre_valid", 32'(o_valid), 32'd1);
        step();
        i_rst = 1'b0;
        i_ready = 1'b1;
        i_weight = 16'h1111;
        i_valid = 4'b1010;
        push_beat(1);
        @(negedge i_clk);
        chk("post_rst_valid", 32'(o_valid), 32'd0);
        chk("post_rst_grant", 32'(o_grant), 32'd0);
        chk("post_rst_ready", 32'(o_ready), 32'd0);
        chk("post_rst_data", o_data, 32'd0);
        step();
        @(negedge i_clk);
        chk("post_rst_idx", 32'(o_grant_idx), 32'd1);
        chk("post_rst_onehot", 32'(o_grant), 32'b0010);
        step();
        i_valid = '0;
        drain("drain_rst");

        repeat (3) step();
        chk("sb_final", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
